spi_memory_router: RTL and testbench

Parametrised SPI-to-memory router sitting between the clock-domain-crossing stage (`write_new`, `read_sync`) and N on-chip memories in the `clk` domain. It decodes the SPI `code` into a channel and drives one shared, registered memory request bus with a one-hot channel select. It sequences reads with a configurable memory latency and captures the read word into `in_message` for SPI shift-out. Compared with per-memory ad-hoc muxing, it adds:

- write buffering while processing owns the memories;
- read/write collision ordering;
- out-of-range code detection.

---
 rtl/spi_memory_router.sv | 209 ++++++++++++++++++++
 tb/tb_spi_memory_router.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_memory_router.sv
// spi_memory_router: routes SPI read/write words onto one shared, registered
// memory request bus with a one-hot channel select. Writes go through a
// one-deep buffer, reads are sequenced with a fixed memory latency, and
// unmapped codes are flagged.
module spi_memory_router #(
  parameter int NUM_CHANNELS            = 4,
  parameter int CODE_BIT_WIDTH          = 4,
  parameter int CODE_BASE               = 1,
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int START_ADDRESS_BIT_WIDTH = 16,
  parameter int READ_LATENCY            = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable_configuration,
  input  logic                                      write_new,
  input  logic                                      read_sync,
  input  logic [CODE_BIT_WIDTH-1:0]                 code,
  input  logic [START_ADDRESS_BIT_WIDTH-1:0]        spi_address,
  input  logic [MESSAGE_BIT_WIDTH-1:0]              spi_data_in,
  output logic [NUM_CHANNELS-1:0]                   mem_select,
  output logic                                      mem_write,
  output logic                                      mem_read,
  output logic [START_ADDRESS_BIT_WIDTH-1:0]        mem_address,
  output logic [MESSAGE_BIT_WIDTH-1:0]              mem_data,
  input  logic [NUM_CHANNELS*MESSAGE_BIT_WIDTH-1:0] mem_read_data,
  output logic [MESSAGE_BIT_WIDTH-1:0]              in_message,
  output logic                                      in_message_valid,
  output logic                                      busy,
  output logic                                      code_error,
  output logic                                      write_overflow
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int IW    = CODE_BIT_WIDTH + 1;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [IW-1:0]    BASE_C   = IW'(CODE_BASE);
  localparam logic [IW-1:0]    NCH_C    = IW'(NUM_CHANNELS);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  // Returns {unmapped, channel} for an SPI code.
  function automatic logic [CH_W:0] decode(input logic [CODE_BIT_WIDTH-1:0] c);
    logic [IW-1:0] idx;
    logic          bad;
    idx = {1'b0, c} - BASE_C;
    bad = ({1'b0, c} < BASE_C) || (idx >= NCH_C);
    return {bad, idx[CH_W-1:0]};
  endfunction

  function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CHANNELS-1:0] r;
    r     = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  state_t                               state;
  logic                                 read_sync_p0;
  logic [CNT_W-1:0]                     wait_cnt;

  logic                                 wr_pend;
  logic [CH_W-1:0]                      wr_ch;
  logic [START_ADDRESS_BIT_WIDTH-1:0]   wr_addr;
  logic [MESSAGE_BIT_WIDTH-1:0]         wr_data;

  logic                                 rd_pend;
  logic                                 rd_bad_q;
  logic [CH_W-1:0]                      rd_ch_q;
  logic [START_ADDRESS_BIT_WIDTH-1:0]   rd_addr_q;

  logic                                 cur_bad;
  logic [CH_W-1:0]                      cur_ch;

  logic                                 new_bad;
  logic [CH_W-1:0]                      new_ch;
  logic                                 read_rise;
  logic                                 wr_new_ok;
  logic                                 wr_avail;
  logic                                 wr_store;
  logic [CH_W-1:0]                      wr_src_ch;
  logic [START_ADDRESS_BIT_WIDTH-1:0]   wr_src_addr;
  logic [MESSAGE_BIT_WIDTH-1:0]         wr_src_data;
  logic                                 rd_req;
  logic                                 rq_bad;
  logic [CH_W-1:0]                      rq_ch;
  logic [START_ADDRESS_BIT_WIDTH-1:0]   rq_addr;
  logic                                 path_free;
  logic                                 wr_go;
  logic                                 rd_go;

  // Request decode and arbitration: a buffered write drains before a new one,
  // and any write wins over a read on the same edge.
  always_comb begin
    {new_bad, new_ch} = decode(code);
    read_rise   = read_sync & ~read_sync_p0;
    wr_new_ok   = write_new & ~new_bad;
    wr_avail    = wr_pend | wr_new_ok;
    wr_src_ch   = wr_pend ? wr_ch   : new_ch;
    wr_src_addr = wr_pend ? wr_addr : spi_address;
    wr_src_data = wr_pend ? wr_data : spi_data_in;
    rd_req      = rd_pend | read_rise;
    rq_bad      = rd_pend ? rd_bad_q  : new_bad;
    rq_ch       = rd_pend ? rd_ch_q   : new_ch;
    rq_addr     = rd_pend ? rd_addr_q : spi_address;
    path_free   = (state == IDLE) && enable_configuration;
    wr_go       = path_free & wr_avail;
    rd_go       = path_free & ~wr_avail & rd_req;
    // A new write is buffered if it cannot issue now, or if the old buffered
    // write issues this edge and frees the slot.
    wr_store    = wr_new_ok & (wr_pend ? wr_go : ~wr_go);
  end

  assign busy = wr_pend | rd_pend | (state != IDLE);

  // Write buffer, read-pending latch, read sequencer and registered memory bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      read_sync_p0     <= 1'b0;
      wait_cnt         <= '0;
      wr_pend          <= 1'b0;
      wr_ch            <= '0;
      wr_addr          <= '0;
      wr_data          <= '0;
      rd_pend          <= 1'b0;
      rd_bad_q         <= 1'b0;
      rd_ch_q          <= '0;
      rd_addr_q        <= '0;
      cur_bad          <= 1'b0;
      cur_ch           <= '0;
      mem_select       <= '0;
      mem_write        <= 1'b0;
      mem_read         <= 1'b0;
      mem_address      <= '0;
      mem_data         <= '0;
      in_message       <= '0;
      in_message_valid <= 1'b0;
      code_error       <= 1'b0;
      write_overflow   <= 1'b0;
    end else begin
      read_sync_p0     <= read_sync;
      mem_write        <= 1'b0;
      mem_read         <= 1'b0;
      in_message_valid <= 1'b0;

      if ((write_new || read_rise) && new_bad)
        code_error <= 1'b1;

      // ---- write issue / buffer ----
      if (wr_go) begin
        mem_write   <= 1'b1;
        mem_select  <= onehot(wr_src_ch);
        mem_address <= wr_src_addr;
        mem_data    <= wr_src_data;
      end
      if (wr_store) begin
        wr_ch   <= new_ch;
        wr_addr <= spi_address;
        wr_data <= spi_data_in;
      end
      wr_pend <= wr_store | (wr_pend & ~wr_go);
      if (wr_new_ok && wr_pend && !wr_go)
        write_overflow <= 1'b1;

      // ---- read request hold ----
      if (rd_go) begin
        rd_pend <= 1'b0;
      end else if (read_rise && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_bad_q  <= new_bad;
        rd_ch_q   <= new_ch;
        rd_addr_q <= spi_address;
      end

      // ---- read sequencer ----
      // wait_cnt counts the remaining WAIT cycles so that capture lands
      // READ_LATENCY cycles after the memory samples the request.
      case (state)
        IDLE: begin
          if (rd_go) begin
            state    <= WAIT;
            wait_cnt <= WAIT_LD;
            cur_bad  <= rq_bad;
            cur_ch   <= rq_ch;
            if (!rq_bad) begin
              mem_read    <= 1'b1;
              mem_select  <= onehot(rq_ch);
              mem_address <= rq_addr;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CAPTURE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        CAPTURE: begin
          in_message       <= cur_bad ? '0
                              : mem_read_data[cur_ch*MESSAGE_BIT_WIDTH +: MESSAGE_BIT_WIDTH];
          in_message_valid <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_memory_router.sv
// Scoreboard bench for spi_memory_router: stimulus pushes expected bus events
// (kind, cycle, fields) into a queue; a negedge monitor pops and compares.
module tb_spi_memory_router;

  localparam int RL = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable_configuration;
  logic         write_new;
  logic         read_sync;
  logic [3:0]   code;
  logic [15:0]  spi_address;
  logic [31:0]  spi_data_in;
  logic [3:0]   mem_select;
  logic         mem_write;
  logic         mem_read;
  logic [15:0]  mem_address;
  logic [31:0]  mem_data;
  logic [127:0] mem_read_data;
  logic [31:0]  in_message;
  logic         in_message_valid;
  logic         busy;
  logic         code_error;
  logic         write_overflow;

  spi_memory_router #(
    .NUM_CHANNELS(4), .CODE_BIT_WIDTH(4), .CODE_BASE(1),
    .MESSAGE_BIT_WIDTH(32), .START_ADDRESS_BIT_WIDTH(16), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .enable_configuration(enable_configuration),
    .write_new(write_new), .read_sync(read_sync), .code(code),
    .spi_address(spi_address), .spi_data_in(spi_data_in),
    .mem_select(mem_select), .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_read_data(mem_read_data), .in_message(in_message),
    .in_message_valid(in_message_valid), .busy(busy),
    .code_error(code_error), .write_overflow(write_overflow)
  );

  always #5 clk = ~clk;

  assign mem_read_data = {32'h0D0D_0003, 32'hCAFE_0002, 32'hBEEF_0001, 32'h1234_5678};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 write strobe, 1 read strobe, 2 capture
    int          cyc;
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input int kind, input int c, input logic [3:0] sel,
                      input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.cyc = c; e.sel = sel; e.addr = addr; e.data = data;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_evt(input int kind, input logic [3:0] sel,
                           input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    bit   bad;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d sel %b addr %h data %h, none expected",
               kind, cyc, sel, addr, data);
    end else begin
      e   = q.pop_front();
      bad = (e.kind != kind) || (e.cyc != cyc);
      if (kind != 2) bad = bad || (e.sel !== sel) || (e.addr !== addr);
      if (kind != 1) bad = bad || (e.data !== data);
      if (bad) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d sel %b addr %h data %h, expected kind %0d cyc %0d sel %b addr %h data %h",
                 kind, cyc, sel, addr, data, e.kind, e.cyc, e.sel, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write)        check_evt(0, mem_select, mem_address, mem_data);
      if (mem_read)         check_evt(1, mem_select, mem_address, 32'h0);
      if (in_message_valid) check_evt(2, 4'b0, 16'h0, in_message);
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d events still outstanding, required 0", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  int c;

  initial begin
    rst = 1'b1; enable_configuration = 1'b0; write_new = 1'b0; read_sync = 1'b0;
    code = '0; spi_address = '0; spi_data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_mem_select", {28'h0, mem_select}, 32'h0);
    chk("reset_strobes", {29'h0, mem_write, mem_read, in_message_valid}, 32'h0);
    chk("reset_in_message", in_message, 32'h0);
    chk("reset_flags", {29'h0, busy, code_error, write_overflow}, 32'h0);
    rst = 1'b0;
    enable_configuration = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write: code 2 -> channel 1
    c = cyc;
    code = 4'd2; spi_address = 16'h0010; spi_data_in = 32'hA5A5_0001; write_new = 1'b1;
    push(0, c + 1, 4'b0010, 16'h0010, 32'hA5A5_0001);
    @(negedge clk);
    write_new = 1'b0;
    chk("write_not_busy", {31'h0, busy}, 32'h0);
    wait_idle("basic_write");

    // Read, latency RL, read_sync held 8 cycles
    c = cyc;
    code = 4'd1; spi_address = 16'h0020; read_sync = 1'b1;
    push(1, c + 1, 4'b0001, 16'h0020, 32'h0);
    push(2, c + 2 + RL, 4'b0, 16'h0, 32'h1234_5678);
    @(negedge clk);
    chk("read_busy", {31'h0, busy}, 32'h1);
    repeat (7) @(negedge clk);
    read_sync = 1'b0;
    wait_idle("read_latency");

    // Gated write, then overflow, then release
    enable_configuration = 1'b0;
    code = 4'd3; spi_address = 16'h0030; spi_data_in = 32'h3333_0003; write_new = 1'b1;
    @(negedge clk);
    write_new = 1'b0;
    chk("gated_busy", {31'h0, busy}, 32'h1);
    repeat (2) @(negedge clk);
    code = 4'd4; spi_address = 16'h0040; spi_data_in = 32'h4444_0004; write_new = 1'b1;
    @(negedge clk);
    write_new = 1'b0;
    chk("write_overflow", {31'h0, write_overflow}, 32'h1);
    repeat (2) @(negedge clk);
    c = cyc;
    enable_configuration = 1'b1;
    push(0, c + 1, 4'b0100, 16'h0030, 32'h3333_0003);
    wait_idle("gated_write");
    chk("gated_idle", {31'h0, busy}, 32'h0);

    // Collision: write and read rise on the same edge
    c = cyc;
    code = 4'd4; spi_address = 16'h0050; spi_data_in = 32'h5555_0005;
    write_new = 1'b1; read_sync = 1'b1;
    push(0, c + 1, 4'b1000, 16'h0050, 32'h5555_0005);
    push(1, c + 2, 4'b1000, 16'h0050, 32'h0);
    push(2, c + 3 + RL, 4'b0, 16'h0, 32'h0D0D_0003);
    @(negedge clk);
    write_new = 1'b0;
    repeat (3) @(negedge clk);
    read_sync = 1'b0;
    wait_idle("collision");

    // Unmapped write (code 0): no strobe, code_error
    chk("code_error_clear", {31'h0, code_error}, 32'h0);
    code = 4'd0; spi_address = 16'h0060; spi_data_in = 32'h6666_0006; write_new = 1'b1;
    @(negedge clk);
    write_new = 1'b0;
    chk("unmapped_write_error", {31'h0, code_error}, 32'h1);
    chk("unmapped_write_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);

    // Unmapped read (code 5): no strobe, captures 0 at normal latency
    c = cyc;
    code = 4'd5; spi_address = 16'h0070; read_sync = 1'b1;
    push(2, c + 2 + RL, 4'b0, 16'h0, 32'h0);
    repeat (3) @(negedge clk);
    read_sync = 1'b0;
    wait_idle("unmapped_read");

    // Reset during WAIT aborts the read
    c = cyc;
    code = 4'd2; spi_address = 16'h0071; read_sync = 1'b1;
    push(1, c + 1, 4'b0010, 16'h0071, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_select", {28'h0, mem_select}, 32'h0);
    chk("midreset_in_message", in_message, 32'h0);
    chk("midreset_flags", {29'h0, busy, code_error, write_overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0; read_sync = 1'b0;
    repeat (RL + 4) @(negedge clk);
    wait_idle("reset_read");

    // New read after reset completes normally
    c = cyc;
    code = 4'd2; spi_address = 16'h0072; read_sync = 1'b1;
    push(1, c + 1, 4'b0010, 16'h0072, 32'h0);
    push(2, c + 2 + RL, 4'b0, 16'h0, 32'hBEEF_0001);
    repeat (2) @(negedge clk);
    read_sync = 1'b0;
    wait_idle("post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
